regfile_mp_sb: RTL and testbench

Parametrised general-purpose register file for the static pipeline CPU: configurable data width and depth, two read ports, two write ports and a per-register pending scoreboard. It sits in the decode/writeback stages. Write port 0 serves the normal WB stage and write port 1 serves the long-latency MUL/DIV unit. Writes are on the rising edge, and internal write-first bypass removes the need for a falling-edge write.

---
 rtl/regfile_mp_sb.sv | 160 ++++++++++++++++
 tb/tb_regfile_mp_sb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb -- general-purpose register file with a long-latency scoreboard.
//
// Two combinational read ports (A, B) and two rising-edge write ports:
// w0 serves writeback, w1 serves the MUL/DIV unit and retires that
// register's pending bit. A write is visible on the read ports in the
// same cycle through an internal bypass, so no falling-edge write is needed.
//
// Ports:
//   RF_clk, RF_rst            clock (rising edge), async active-high reset
//   RF_ena                    global enable; low freezes state and zeroes reads
//   ra_addr/ra_data/ra_pend   read port A: address, data, pending flag
//   rb_addr/rb_data/rb_pend   read port B: address, data, pending flag
//   w0_en/w0_addr/w0_data     writeback write port; wins address collisions
//   w1_en/w1_addr/w1_data     MUL/DIV write port; also clears pend[w1_addr]
//   pend_set/pend_addr        marks a register as awaiting a long-latency result
//   pend_cnt                  number of registers currently pending

// One read port: applies the zero-register, bypass and pending-mask rules
// to the stored word and pending bit that the parent selects.
module regfile_mp_sb_rdport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              ena,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] stored,
    input  logic              stored_pend,
    input  logic              w0_en,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [DATA_W-1:0] w0_data,
    input  logic              w1_en,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [DATA_W-1:0] w1_data,
    output logic [DATA_W-1:0] data,
    output logic              pend
);
    logic is_r0, w0_hit, w1_hit;

    assign is_r0  = (ZERO_REG != 0) && (addr == '0);
    assign w0_hit = w0_en && (w0_addr == addr);
    assign w1_hit = w1_en && (w1_addr == addr);

    always_comb begin
        data = '0;
        if (ena && !is_r0) begin
            if (w0_hit)      data = w0_data;
            else if (w1_hit) data = w1_data;
            else             data = stored;
        end
    end

    // A result landing this cycle is already on the bypass, so the
    // consumer must not stall on it.
    assign pend = ena && stored_pend && !w1_hit;
endmodule

module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              RF_clk,
    input  logic              RF_rst,
    input  logic              RF_ena,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic              ra_pend,
    output logic              rb_pend,
    input  logic              w0_en,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [DATA_W-1:0] w0_data,
    input  logic              w1_en,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [DATA_W-1:0] w1_data,
    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_addr,
    output logic [ADDR_W:0]   pend_cnt
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NRD   = 2;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend;

    // ---------------- read ports ----------------
    logic [NRD-1:0][ADDR_W-1:0] rd_addr;
    logic [NRD-1:0][DATA_W-1:0] rd_stored;
    logic [NRD-1:0][DATA_W-1:0] rd_data;
    logic [NRD-1:0]             rd_stored_pend;
    logic [NRD-1:0]             rd_pend;

    assign rd_addr = {rb_addr, ra_addr};

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        assign rd_stored[g]      = mem[rd_addr[g]];
        assign rd_stored_pend[g] = pend[rd_addr[g]];

        regfile_mp_sb_rdport #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG)
        ) u_rd (
            .ena        (RF_ena),
            .addr       (rd_addr[g]),
            .stored     (rd_stored[g]),
            .stored_pend(rd_stored_pend[g]),
            .w0_en      (w0_en),
            .w0_addr    (w0_addr),
            .w0_data    (w0_data),
            .w1_en      (w1_en),
            .w1_addr    (w1_addr),
            .w1_data    (w1_data),
            .data       (rd_data[g]),
            .pend       (rd_pend[g])
        );
    end

    assign ra_data = rd_data[0];
    assign rb_data = rd_data[1];
    assign ra_pend = rd_pend[0];
    assign rb_pend = rd_pend[1];

    // ---------------- write / scoreboard update ----------------
    logic w0_r0, w1_r0, ps_r0;
    logic w0_we, w1_we, set_eff, clr_eff;
    logic inc, dec;

    assign w0_r0 = (ZERO_REG != 0) && (w0_addr == '0);
    assign w1_r0 = (ZERO_REG != 0) && (w1_addr == '0);
    assign ps_r0 = (ZERO_REG != 0) && (pend_addr == '0);

    assign w0_we   = RF_ena && w0_en && !w0_r0;
    assign w1_we   = RF_ena && w1_en && !w1_r0;
    assign set_eff = RF_ena && pend_set && !ps_r0;
    assign clr_eff = RF_ena && w1_en;

    // Count tracks actual bit transitions: a set only counts on a 0->1 edge,
    // and a clear only on 1->0 unless the same-cycle set overrides it.
    assign inc = set_eff && !pend[pend_addr];
    assign dec = clr_eff && pend[w1_addr] && !(set_eff && (pend_addr == w1_addr));

    always_ff @(posedge RF_clk or posedge RF_rst) begin
        if (RF_rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            // w0 is applied last so it wins a same-address collision.
            if (w1_we) mem[w1_addr] <= w1_data;
            if (w0_we) mem[w0_addr] <= w0_data;
            // Set applied after clear so it wins a same-address collision.
            if (clr_eff) pend[w1_addr]   <= 1'b0;
            if (set_eff) pend[pend_addr] <= 1'b1;
            pend_cnt <= pend_cnt + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};
        end
    end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Randomised + directed bench for regfile_mp_sb. The stimulus process drives
// one cycle at a time, predicts the outputs from an architectural model and
// queues them; a monitor on the falling edge pops and compares.
module tb_regfile_mp_sb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 1 << AW;

    logic          RF_clk = 0, RF_rst = 1, RF_ena = 0;
    logic [AW-1:0] ra_addr = 0, rb_addr = 0;
    logic [DW-1:0] ra_data, rb_data;
    logic          ra_pend, rb_pend;
    logic          w0_en = 0, w1_en = 0, pend_set = 0;
    logic [AW-1:0] w0_addr = 0, w1_addr = 0, pend_addr = 0;
    logic [DW-1:0] w0_data = 0, w1_data = 0;
    logic [AW:0]   pend_cnt;

    regfile_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
        .RF_clk(RF_clk), .RF_rst(RF_rst), .RF_ena(RF_ena),
        .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(ra_data), .rb_data(rb_data),
        .ra_pend(ra_pend), .rb_pend(rb_pend),
        .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
        .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
        .pend_set(pend_set), .pend_addr(pend_addr),
        .pend_cnt(pend_cnt)
    );

    always #5 RF_clk = ~RF_clk;

    typedef struct {
        logic [DW-1:0] ra, rb;
        logic          rap, rbp;
        int            cnt;
        int            id;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_fail = 0, n_tick = 0;

    // architectural state
    logic [DW-1:0] m_reg [DEPTH];
    bit            m_pend [DEPTH];

    function automatic logic [DW-1:0] m_read(input int a);
        if (!RF_ena || a == 0)            return '0;
        if (w0_en && int'(w0_addr) == a)  return w0_data;
        if (w1_en && int'(w1_addr) == a)  return w1_data;
        return m_reg[a];
    endfunction

    function automatic logic m_pnd(input int a);
        return RF_ena && m_pend[a] && !(w1_en && int'(w1_addr) == a);
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += m_pend[i] ? 1 : 0;
        return c;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 0;
        end
    endtask

    // Predict this cycle's outputs from the currently driven inputs, then
    // advance the model across the coming rising edge.
    task automatic tick();
        exp_t e;
        if (RF_rst) m_clear();
        e.ra  = m_read(int'(ra_addr));
        e.rb  = m_read(int'(rb_addr));
        e.rap = m_pnd(int'(ra_addr));
        e.rbp = m_pnd(int'(rb_addr));
        e.cnt = m_count();
        e.id  = n_tick++;
        q.push_back(e);
        if (!RF_rst && RF_ena) begin
            if (w1_en && w1_addr != 0) m_reg[w1_addr] = w1_data;
            if (w0_en && w0_addr != 0) m_reg[w0_addr] = w0_data;
            if (w1_en) m_pend[w1_addr] = 0;
            if (pend_set && pend_addr != 0) m_pend[pend_addr] = 1;
        end
        @(posedge RF_clk);
        #1;
    endtask

    task automatic idle();
        w0_en = 0; w1_en = 0; pend_set = 0;
    endtask

    task automatic chk(input string name, input int id, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, id, act, req);
        end
    endtask

    // monitor
    always @(negedge RF_clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("ra_data", e.id, ra_data, e.ra);
            chk("rb_data", e.id, rb_data, e.rb);
            chk("ra_pend", e.id, DW'(ra_pend), DW'(e.rap));
            chk("rb_pend", e.id, DW'(rb_pend), DW'(e.rbp));
            chk("pend_cnt", e.id, DW'(pend_cnt), DW'(e.cnt));
        end
    end

    function automatic logic [AW-1:0] raddr();
        return ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
    endfunction

    initial begin
        m_clear();
        repeat (2) @(posedge RF_clk);
        #1;
        // reset state
        RF_ena = 1; ra_addr = 0; rb_addr = 31;
        tick();
        RF_rst = 0;

        // reset mid-operation
        w0_en = 1; w0_addr = 5; w0_data = 32'h1234; pend_set = 1; pend_addr = 7;
        tick();
        idle(); ra_addr = 5; rb_addr = 7;
        tick();
        RF_rst = 1;
        tick();
        RF_rst = 0;
        tick();

        // bypass and port priority
        w0_en = 1; w0_addr = 3; w0_data = 32'hAAAA5555;
        w1_en = 1; w1_addr = 3; w1_data = 32'h11112222; ra_addr = 3;
        tick();
        idle();
        tick();

        // zero register
        w0_en = 1; w0_addr = 0; w0_data = 32'hFFFFFFFF; pend_set = 1; pend_addr = 0;
        ra_addr = 0; rb_addr = 0;
        tick();
        idle();
        tick();

        // scoreboard set / clear
        pend_set = 1; pend_addr = 8; rb_addr = 8;
        tick();
        idle();
        tick();
        w1_en = 1; w1_addr = 8; w1_data = 32'h42;
        tick();
        idle();
        tick();

        // simultaneous set and clear
        pend_set = 1; pend_addr = 9; w1_en = 1; w1_addr = 9; w1_data = 32'h9; ra_addr = 9;
        tick();
        idle();
        tick();
        pend_set = 1; pend_addr = 10; w1_en = 1; w1_addr = 9; w1_data = 32'h99; rb_addr = 10;
        tick();
        idle();
        tick();

        // enable gating
        w0_en = 1; w0_addr = 4; w0_data = 32'h77;
        tick();
        RF_ena = 0; w0_data = 32'h55; pend_set = 1; pend_addr = 4; ra_addr = 4;
        tick();
        RF_ena = 1; idle();
        tick();

        // count saturation: mark every register pending
        for (int i = 0; i < DEPTH; i++) begin
            pend_set = 1; pend_addr = AW'(i);
            tick();
        end
        idle();
        tick();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            RF_rst    = ($urandom_range(0, 249) == 0);
            RF_ena    = ($urandom_range(0, 7) != 0);
            ra_addr   = raddr();
            rb_addr   = raddr();
            w0_en     = ($urandom_range(0, 1) == 0);
            w0_addr   = raddr();
            w0_data   = $urandom;
            w1_en     = ($urandom_range(0, 4) < 2);
            w1_addr   = raddr();
            w1_data   = $urandom;
            pend_set  = ($urandom_range(0, 4) < 2);
            pend_addr = raddr();
            tick();
        end
        RF_rst = 0; RF_ena = 1; idle();
        tick();

        // drain, bounded
        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge RF_clk);
        if (q.size() > 0) begin
            n_chk++; n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
